// File: rtl/pipes_pkg.sv
// Shared pipeline definitions: buffer state encoding, reset PC and the
// fetch/decode payload layout that gets packed into pipe_stage_buf data.
package pipes;

    // Occupancy of a two-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_BUSY  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Architectural reset PC; also the default payload after reset.
    localparam logic [63:0] PC_RESET = 64'h8000_0000;

    // F/D payload: packed into in_data/out_data at the instantiation site.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    localparam int FETCH_W = $bits(fetch_data_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on en_i, sticks at all-ones, cleared by reset only.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold at the maximum instead of wrapping to zero.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready handshake, synchronous flush,
// optional two-entry skid mode (registered in_ready) and a saturating count
// of back-pressure cycles.
module pipe_stage_buf
    import pipes::*;
#(
    parameter int                DATA_W    = 96,
    parameter logic [DATA_W-1:0] RESET_VAL = {PC_RESET, 32'h0},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    if (SKID != 0) begin : g_skid

        buf_state_t        state_q;
        logic [DATA_W-1:0] main_q;
        logic [DATA_W-1:0] skid_q;
        logic              in_ready_q;
        logic              out_valid_q;

        // Skid FSM: main entry drives the output, skid entry absorbs the one
        // beat that arrives while in_ready was still high. in_ready and
        // out_valid are kept as their own flops so neither has a path from
        // out_ready.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q     <= BUF_EMPTY;
                main_q      <= RESET_VAL;
                skid_q      <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else if (flush_i) begin
                // Drop everything, including a beat accepted this cycle;
                // main keeps its value so out_data does not glitch.
                state_q     <= BUF_EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    BUF_EMPTY: begin
                        if (in_fire) begin
                            main_q      <= in_data_i;
                            state_q     <= BUF_BUSY;
                            out_valid_q <= 1'b1;
                        end
                    end
                    BUF_BUSY: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_data_i;
                        end else if (in_fire) begin
                            skid_q     <= in_data_i;
                            state_q    <= BUF_FULL;
                            in_ready_q <= 1'b0;
                        end else if (out_fire) begin
                            state_q     <= BUF_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                    BUF_FULL: begin
                        // in_ready is low here, so only the drain can happen.
                        if (out_fire) begin
                            main_q     <= skid_q;
                            state_q    <= BUF_BUSY;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= BUF_EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end

        assign in_ready_o  = in_ready_q;
        assign out_valid_o = out_valid_q;
        assign out_data_o  = main_q;

    end else begin : g_reg

        logic [DATA_W-1:0] main_q;
        logic              out_valid_q;

        // Single register: accept whenever the slot is empty or being drained.
        assign in_ready_o = out_ready_i | ~out_valid_q;

        // Single-entry register; a simultaneous in/out fire replaces in place.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                main_q      <= RESET_VAL;
                out_valid_q <= 1'b0;
            end else if (flush_i) begin
                out_valid_q <= 1'b0;
            end else if (in_fire) begin
                main_q      <= in_data_i;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end

        assign out_valid_o = out_valid_q;
        assign out_data_o  = main_q;

    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (out_valid_o & ~out_ready_i),
        .count_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (skid, skid with 4-bit counter,
// single register) share one input stream and are compared every cycle
// against queue-based reference models, plus table vectors and hand sequences.
module tb_pipe_stage_buf;

    localparam logic [95:0] RST_V = {64'h8000_0000, 32'h0};
    localparam logic [95:0] VA = 96'h0A;
    localparam logic [95:0] VB = 96'h0B;
    localparam logic [95:0] VC = 96'h0C;
    localparam logic [95:0] VD = 96'h0D;
    localparam logic [95:0] VE = 96'h0E;
    localparam logic [95:0] VF = 96'h0F;
    localparam logic [95:0] VG = 96'h10;
    localparam logic [95:0] VH = 96'h11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [95:0] in_data = '0;

    logic        ir_s, ov_s, ir_t, ov_t, ir_r, ov_r;
    logic [95:0] od_s, od_t, od_r;
    logic [31:0] sc_s;
    logic [3:0]  sc_t;
    logic [7:0]  sc_r;

    int total = 0;
    int bad = 0;

    // Reference model state: occupancy queues, last shown value, counters.
    logic [95:0] q_a[$];
    logic [95:0] q_b[$];
    logic [95:0] shown_a, shown_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_s;
    logic [7:0]  cnt_b;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [95:0] d;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [95:0] od;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    pipe_stage_buf #(.SKID(1), .CNT_W(32)) u_skid (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_s), .in_data_i(in_data), .out_valid_o(ov_s),
        .out_ready_i(out_ready), .out_data_o(od_s), .stall_cnt_o(sc_s));

    pipe_stage_buf #(.SKID(1), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_t), .in_data_i(in_data), .out_valid_o(ov_t),
        .out_ready_i(out_ready), .out_data_o(od_t), .stall_cnt_o(sc_t));

    pipe_stage_buf #(.SKID(0), .CNT_W(8)) u_reg (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_r), .in_data_i(in_data), .out_valid_o(ov_r),
        .out_ready_i(out_ready), .out_data_o(od_r), .stall_cnt_o(sc_r));

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        shown_a = RST_V;
        shown_b = RST_V;
        cnt_a = '0;
        cnt_s = '0;
        cnt_b = '0;
    endtask

    // One clock edge: check pre-edge in_ready, advance models, check outputs.
    task automatic step();
        logic ir_a, ir_b, fa, fb, oa, ob;
        #1;
        ir_a = (q_a.size() < 2);
        ir_b = out_ready || (q_b.size() == 0);
        chk("in_ready_skid", ir_s, ir_a);
        chk("in_ready_sat", ir_t, ir_a);
        chk("in_ready_reg", ir_r, ir_b);
        @(posedge clk);
        fa = in_valid && ir_a;
        fb = in_valid && ir_b;
        oa = (q_a.size() > 0) && out_ready;
        ob = (q_b.size() > 0) && out_ready;
        if ((q_a.size() > 0) && !out_ready) begin
            if (cnt_a != 32'hFFFF_FFFF) cnt_a = cnt_a + 32'd1;
            if (cnt_s != 4'hF) cnt_s = cnt_s + 4'd1;
        end
        if ((q_b.size() > 0) && !out_ready) begin
            if (cnt_b != 8'hFF) cnt_b = cnt_b + 8'd1;
        end
        if (flush) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (oa) void'(q_a.pop_front());
            if (fa) q_a.push_back(in_data);
            if (ob) void'(q_b.pop_front());
            if (fb) q_b.push_back(in_data);
        end
        if (q_a.size() > 0) shown_a = q_a[0];
        if (q_b.size() > 0) shown_b = q_b[0];
        #1;
        chk("out_valid_skid", {95'd0, ov_s}, {95'd0, q_a.size() > 0});
        chk("out_valid_sat", {95'd0, ov_t}, {95'd0, q_a.size() > 0});
        chk("out_valid_reg", {95'd0, ov_r}, {95'd0, q_b.size() > 0});
        chk("out_data_skid", od_s, shown_a);
        chk("out_data_sat", od_t, shown_a);
        chk("out_data_reg", od_r, shown_b);
        chk("stall_skid", {64'd0, sc_s}, {64'd0, cnt_a});
        chk("stall_sat", {92'd0, sc_t}, {92'd0, cnt_s});
        chk("stall_reg", {88'd0, sc_r}, {88'd0, cnt_b});
    endtask

    // Asynchronous reset pulse in the middle of a clock period.
    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        chk("rst_ov_skid", {95'd0, ov_s}, 96'd0);
        chk("rst_ov_reg", {95'd0, ov_r}, 96'd0);
        chk("rst_od_skid", od_s, RST_V);
        chk("rst_od_reg", od_r, RST_V);
        chk("rst_ir_skid", {95'd0, ir_s}, 96'd1);
        chk("rst_cnt_skid", {64'd0, sc_s}, 96'd0);
        chk("rst_cnt_sat", {92'd0, sc_t}, 96'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, VA, 1'b0, 1'b1, 1'b1, VA};
        tbl[1]  = '{1'b0, 1'b1, VB, 1'b0, 1'b1, 1'b0, VA};
        tbl[2]  = '{1'b0, 1'b1, VC, 1'b0, 1'b1, 1'b0, VA};
        tbl[3]  = '{1'b0, 1'b1, VC, 1'b1, 1'b1, 1'b1, VB};
        tbl[4]  = '{1'b0, 1'b1, VC, 1'b1, 1'b1, 1'b1, VC};
        tbl[5]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, VC};
        tbl[6]  = '{1'b0, 1'b1, VE, 1'b0, 1'b1, 1'b1, VE};
        tbl[7]  = '{1'b0, 1'b1, VF, 1'b0, 1'b1, 1'b0, VE};
        tbl[8]  = '{1'b1, 1'b1, VD, 1'b0, 1'b0, 1'b1, VE};
        tbl[9]  = '{1'b0, 1'b0, VD, 1'b0, 1'b0, 1'b1, VE};
        tbl[10] = '{1'b1, 1'b1, VD, 1'b0, 1'b0, 1'b1, VE};
        tbl[11] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, VE};
        tbl[12] = '{1'b0, 1'b1, VG, 1'b1, 1'b1, 1'b1, VG};
        tbl[13] = '{1'b1, 1'b1, VH, 1'b1, 1'b0, 1'b1, VG};

        // Reset state, seen before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("init_ov", {95'd0, ov_s}, 96'd0);
        chk("init_od", od_s, RST_V);
        chk("init_cnt", {64'd0, sc_s}, 96'd0);
        model_reset();
        #20 rst_n = 1'b1;

        // First transfer after reset: one-cycle latency.
        in_valid = 1'b1;
        in_data = 96'h0000_0000_8000_0000_1000_0013;
        step();
        chk("first_ov", {95'd0, ov_s}, 96'd1);
        chk("first_od", od_s, 96'h0000_0000_8000_0000_1000_0013);
        in_data = 96'h1234;
        step();

        // Asynchronous reset while data is buffered and a beat is offered.
        reset_mid();

        // Back-pressure ordering and flush collisions on the skid instance.
        for (int i = 0; i < 14; i++) begin
            flush = tbl[i].fl;
            in_valid = tbl[i].iv;
            in_data = tbl[i].d;
            out_ready = tbl[i].ordy;
            step();
            chk($sformatf("vec%0d_ov", i), {95'd0, ov_s}, {95'd0, tbl[i].ov});
            chk($sformatf("vec%0d_ir", i), {95'd0, ir_s}, {95'd0, tbl[i].ir});
            chk($sformatf("vec%0d_od", i), od_s, tbl[i].od);
        end
        flush = 1'b0;

        // Counter saturation: one beat held for 20 stalled cycles.
        in_valid = 1'b1;
        in_data = 96'h5A5A;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", {92'd0, sc_t}, 96'd15);
        step();
        chk("sat_hold", {92'd0, sc_t}, 96'd15);

        // Single-register mode: in_ready follows out_ready combinationally.
        in_valid = 1'b1;
        in_data = 96'h7777;
        #1;
        chk("reg_ir_blocked", {95'd0, ir_r}, 96'd0);
        out_ready = 1'b1;
        #1;
        chk("reg_ir_open", {95'd0, ir_r}, 96'd1);
        step();
        chk("reg_replace_ov", {95'd0, ov_r}, 96'd1);
        chk("reg_replace_od", od_r, 96'h7777);

        // Full throughput from a clean reset.
        reset_mid();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 96'h1000 + 96'(i);
            step();
            chk("tput_data", od_s, 96'h1000 + 96'(i));
            chk("tput_ready", {95'd0, ir_s}, 96'd1);
        end
        chk("tput_stall_skid", {64'd0, sc_s}, 96'd0);
        chk("tput_stall_reg", {88'd0, sc_r}, 96'd0);

        // Randomised traffic against the models.
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data = {$urandom, $urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer, the general successor to the fixed fetch/decode register. It carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake, synchronous flush and an optional two-entry skid mode that registers `in_ready`. It also keeps a saturating count of back-pressure cycles. One instance sits between each pair of stages: F/D, D/E, E/M and M/W.

## Interface
- `DATA_W`, default 96: payload width in bits; the F/D default is 64-bit pc plus 32-bit instruction.
- `RESET_VAL`, default `{64'h8000_0000, 32'h0}`: value of `out_data` after reset.
- `SKID`, default 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous; discards all buffered entries.
- `in_valid`  in  1: upstream payload valid.
- `in_ready`  out  1: buffer can accept a payload.
- `in_data`  in  `DATA_W`: upstream payload.
- `out_valid`  out  1: `out_data` holds a valid payload.
- `out_ready`  in  1: downstream accepts the payload.
- `out_data`  out  `DATA_W`: payload presented downstream.
- `stall_cnt`  out  `CNT_W`: count of cycles with `out_valid & ~out_ready`.

## Operation
- A transfer happens on an edge where `valid & ready` holds. This gives `in_fire` on the input side and `out_fire` on the output side.
- Reset (`reset`=0, asynchronous) sets the state to EMPTY, `out_valid`=0, `out_data`=`RESET_VAL`, skid entry to 0 and `stall_cnt`=0.
- SKID=1 uses three states:
  - EMPTY: `in_ready`=1. On `in_fire`, main is loaded and the state goes to BUSY.
  - BUSY: `in_ready`=1.
    - `in_fire` and `out_fire` together: main is replaced, state stays BUSY.
    - `in_fire` alone: skid captures `in_data`, state goes to FULL.
    - `out_fire` alone: state goes to EMPTY.
  - FULL: `in_ready`=0. On `out_fire`, main is loaded from skid and the state goes to BUSY.
- SKID=0:
  - `in_ready` = `out_ready | ~out_valid`.
  - On `in_fire`, main is loaded and `out_valid` goes to 1.
  - On `out_fire` without `in_fire`, `out_valid` goes to 0.
- `out_valid` = 1 in BUSY and FULL.
- `out_data` is always the main entry. When empty it holds the last value, or `RESET_VAL` after reset.
- Flush has priority over every other event. On the edge where `flush`=1:
  - the state goes to EMPTY and `out_valid` goes to 0;
  - an `in_fire` in the same cycle is dropped;
  - `out_data` is unchanged.
- `stall_cnt` increments by 1 on each edge where `out_valid & ~out_ready`, including flush cycles. It saturates at 2^`CNT_W`−1 and is cleared only by reset.

## Timing
- Latency is 1 cycle: data accepted on edge N is on `out_data` after edge N.
- Throughput is 1 beat/cycle in both modes.
- SKID=1: `in_ready` is a pure register output with no combinational path from `out_ready`.
- SKID=0: `in_ready` depends combinationally on `out_ready`.
- Ordering is strict FIFO and no beat is ever lost except by flush.
- `out_valid`, once asserted, stays asserted with stable `out_data` until `out_fire` or flush.
- Reset asserted mid-transfer takes effect immediately, without waiting for `clk`. The first transfer is possible on the first edge after deassertion.

## Structure
- Shared package `pipes`:
  - add `buf_state_t` enum {`BUF_EMPTY`, `BUF_BUSY`, `BUF_FULL`};
  - add constant `PC_RESET` = 64'h8000_0000;
  - `fetch_data_t` stays there and is packed into `in_data`/`out_data` at instantiation.
- Sub-module `sat_counter`, parametrised on width, with `en` input and saturating increment. It implements `stall_cnt`.

## Test plan
- Reset and first transfer: hold `reset`=0 asynchronously mid-cycle. Expect `out_valid`=0 and `out_data`=`{64'h8000_0000, 32'h0}` immediately. Then release reset and drive `in_data`=0x…1000_0013 valid. Expect it on `out_data` with `out_valid`=1 one edge later.
- Back-pressure (SKID=1):
  - Stream A, B, C with `out_ready`=0. Expect state FULL after B and `in_ready`=0, with C held upstream.
  - Raise `out_ready`. Expect A, B, C output in order with no duplicates.
- Full throughput: continuous `in_valid` and `out_ready` for 100 cycles with incrementing payloads. Expect 100 outputs back-to-back, `in_ready` constantly 1 and `stall_cnt`=0.
- Flush collision:
  - From FULL, assert `flush` together with `in_valid`=D. Expect `out_valid`=0 next cycle and D never appears.
  - Repeat in EMPTY with `in_fire`. Expect D dropped.
- Counter saturation (`CNT_W`=4): hold `out_valid`=1 with `out_ready`=0 for 20 cycles. Expect `stall_cnt`=15 and stays 15.
- SKID=0 mode:
  - With `out_valid`=1 and `out_ready`=0, expect `in_ready`=0 combinationally.
  - Toggle `out_ready` to 1 in the same cycle as `in_valid`. Expect replacement with no bubble.
